traffic_light_ctrl: RTL and testbench



---
 rtl/traffic_pkg.sv | 29 ++
 rtl/traffic_light_ctrl.sv | 144 ++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and default phase durations for the
// two-road traffic light controller.
package traffic_pkg;

   typedef enum logic [2:0] {
      MAIN_G,
      MAIN_Y,
      ALL_RED_1,
      SIDE_G,
      SIDE_Y,
      ALL_RED_2,
      FLASH
   } tl_state_t;

   typedef logic [2:0] lamp_t;

   localparam lamp_t LAMP_R   = 3'b100;
   localparam lamp_t LAMP_Y   = 3'b010;
   localparam lamp_t LAMP_G   = 3'b001;
   localparam lamp_t LAMP_OFF = 3'b000;

   localparam int unsigned D_MAIN_G = 300;
   localparam int unsigned D_MAIN_Y = 30;
   localparam int unsigned D_ALLRED = 10;
   localparam int unsigned D_SIDE_G = 150;
   localparam int unsigned D_SIDE_Y = 30;
   localparam int unsigned D_FLASH  = 5;

endpackage

// File: rtl/traffic_light_ctrl.sv
// Moore phase sequencer for a main/side intersection with
// a pedestrian walk served during side green.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int          W        = 16,
   parameter int unsigned T_MAIN_G = D_MAIN_G,
   parameter int unsigned T_MAIN_Y = D_MAIN_Y,
   parameter int unsigned T_ALLRED = D_ALLRED,
   parameter int unsigned T_SIDE_G = D_SIDE_G,
   parameter int unsigned T_SIDE_Y = D_SIDE_Y,
   parameter int unsigned T_FLASH  = D_FLASH
) (
   input  logic         clk,
   input  logic         arstN,
   input  logic         flag_0,
   input  logic         side_car,
   input  logic         ped_req,
   input  logic         flash_en,
   output logic         counter_set,
   output logic [W-1:0] load,
   output lamp_t        main_light,
   output lamp_t        side_light,
   output logic         walk
);

   localparam logic [63:0] LIM = 64'd1 << W;

   if (64'(T_MAIN_G) >= LIM || 64'(T_MAIN_Y) >= LIM ||
       64'(T_ALLRED) >= LIM || 64'(T_SIDE_G) >= LIM ||
       64'(T_SIDE_Y) >= LIM || 64'(T_FLASH)  >= LIM)
   begin : g_bad_duration
      $error("traffic_light_ctrl: duration exceeds W bits");
   end

   tl_state_t      state_q, state_d;
   logic           blink_q, blink_d;
   logic           pend_q, pend_d;
   logic           walk_d;
   logic           set_d;
   logic [W-1:0]   load_d;
   lamp_t          main_d, side_d;
   logic           expired, ped_any, reload;

   function automatic logic [W-1:0] dur_of(tl_state_t s);
      case (s)
         MAIN_G:    return W'(T_MAIN_G);
         MAIN_Y:    return W'(T_MAIN_Y);
         SIDE_G:    return W'(T_SIDE_G);
         SIDE_Y:    return W'(T_SIDE_Y);
         FLASH:     return W'(T_FLASH);
         default:   return W'(T_ALLRED);
      endcase
   endfunction

   // flag_0 still shows the old count during the load strobe
   assign expired = flag_0 & ~counter_set;
   assign ped_any = pend_q | ped_req;

   always_comb begin
      state_d = state_q;
      blink_d = blink_q;
      walk_d  = walk;
      pend_d  = ped_any;
      reload  = 1'b0;
      if (flash_en && state_q != FLASH) begin
         state_d = FLASH;
         blink_d = 1'b1;
         walk_d  = 1'b0;
      end else begin
         case (state_q)
            MAIN_G:
               if (expired && (side_car | ped_any))
                  state_d = MAIN_Y;
            MAIN_Y:
               if (expired) state_d = ALL_RED_1;
            ALL_RED_1:
               if (expired) begin
                  state_d = SIDE_G;
                  walk_d  = ped_any;
                  pend_d  = 1'b0;
               end
            SIDE_G:
               if (expired) begin
                  state_d = SIDE_Y;
                  walk_d  = 1'b0;
               end
            SIDE_Y:
               if (expired) state_d = ALL_RED_2;
            ALL_RED_2:
               if (expired) state_d = MAIN_G;
            FLASH:
               if (!flash_en) begin
                  state_d = ALL_RED_2;
               end else if (expired) begin
                  blink_d = ~blink_q;
                  reload  = 1'b1;
               end
            default:
               state_d = ALL_RED_2;
         endcase
      end

      set_d  = reload | (state_d != state_q);
      load_d = set_d ? dur_of(state_d) : '0;

      main_d = LAMP_R;
      side_d = LAMP_R;
      case (state_d)
         MAIN_G: main_d = LAMP_G;
         MAIN_Y: main_d = LAMP_Y;
         SIDE_G: side_d = LAMP_G;
         SIDE_Y: side_d = LAMP_Y;
         FLASH: begin
            main_d = blink_d ? LAMP_Y : LAMP_OFF;
            side_d = blink_d ? LAMP_Y : LAMP_OFF;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!arstN) begin
         state_q     <= ALL_RED_2;
         blink_q     <= 1'b1;
         pend_q      <= 1'b0;
         walk        <= 1'b0;
         counter_set <= 1'b1;
         load        <= W'(T_ALLRED);
         main_light  <= LAMP_R;
         side_light  <= LAMP_R;
      end else begin
         state_q     <= state_d;
         blink_q     <= blink_d;
         pend_q      <= pend_d;
         walk        <= walk_d;
         counter_set <= set_d;
         load        <= load_d;
         main_light  <= main_d;
         side_light  <= side_d;
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl with a behavioural countdown
// counter beside it and a time-based phase reference model.
module tb_traffic_light_ctrl;

   localparam int W   = 16;
   localparam int TMG = 4;
   localparam int TMY = 2;
   localparam int TAR = 1;
   localparam int TSG = 3;
   localparam int TSY = 2;
   localparam int TFL = 2;

   localparam int P_MG  = 0;
   localparam int P_MY  = 1;
   localparam int P_AR1 = 2;
   localparam int P_SG  = 3;
   localparam int P_SY  = 4;
   localparam int P_AR2 = 5;
   localparam int P_FL  = 6;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] O = 3'b000;

   logic         clk = 1'b0;
   logic         arstN = 1'b0;
   logic         side_car = 1'b0;
   logic         ped_req = 1'b0;
   logic         flash_en = 1'b0;
   logic         flag_0;
   logic         counter_set;
   logic [W-1:0] load;
   logic [2:0]   main_light, side_light;
   logic         walk;
   logic [W-1:0] cnt = '0;

   int checks = 0;
   int failures = 0;

   int m_ph, m_el;
   bit m_ped, m_walk, m_blink;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (counter_set === 1'b1) cnt <= load;
      else if (cnt != 0) cnt <= cnt - 1'b1;
   end
   assign flag_0 = (cnt == 0);

   traffic_light_ctrl #(
      .W(W), .T_MAIN_G(TMG), .T_MAIN_Y(TMY),
      .T_ALLRED(TAR), .T_SIDE_G(TSG),
      .T_SIDE_Y(TSY), .T_FLASH(TFL)
   ) dut (
      .clk(clk), .arstN(arstN), .flag_0(flag_0),
      .side_car(side_car), .ped_req(ped_req),
      .flash_en(flash_en), .counter_set(counter_set),
      .load(load), .main_light(main_light),
      .side_light(side_light), .walk(walk)
   );

   function automatic int dur(int p);
      case (p)
         P_MG:    return TMG;
         P_MY:    return TMY;
         P_SG:    return TSG;
         P_SY:    return TSY;
         P_FL:    return TFL;
         default: return TAR;
      endcase
   endfunction

   // Phase expires once it has been held for its load value + 1 cycles
   function automatic void model_step(bit r, bit sc, bit pr, bit fe);
      int np;
      bit ex, enter, any;
      if (!r) begin
         m_ph = P_AR2; m_el = 0; m_ped = 0;
         m_walk = 0; m_blink = 1;
         return;
      end
      ex = (m_el >= dur(m_ph) + 1);
      any = m_ped | pr;
      m_ped = any;
      np = m_ph;
      enter = 0;
      if (fe && m_ph != P_FL) begin
         np = P_FL; m_blink = 1; m_walk = 0;
      end else if (m_ph == P_FL) begin
         if (!fe) np = P_AR2;
         else if (ex) begin
            m_blink = !m_blink; enter = 1;
         end
      end else if (ex) begin
         if (m_ph == P_MG) begin
            if (sc || any) np = P_MY;
         end else begin
            np = (m_ph == P_AR2) ? P_MG : m_ph + 1;
         end
         if (np == P_SG) begin
            m_walk = any; m_ped = 0;
         end
         if (m_ph == P_SG) m_walk = 0;
      end
      if (np != m_ph) enter = 1;
      m_ph = np;
      m_el = enter ? 0 : m_el + 1;
   endfunction

   function automatic logic [2:0] exp_main();
      case (m_ph)
         P_MG:    return G;
         P_MY:    return Y;
         P_FL:    return m_blink ? Y : O;
         default: return R;
      endcase
   endfunction

   function automatic logic [2:0] exp_side();
      case (m_ph)
         P_SG:    return G;
         P_SY:    return Y;
         P_FL:    return m_blink ? Y : O;
         default: return R;
      endcase
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, req, $time);
      end
   endtask

   task automatic compare_all();
      bit ok;
      logic [W-1:0] el;
      el = (m_el == 0) ? W'(dur(m_ph)) : '0;
      chk("main", 32'(main_light), 32'(exp_main()));
      chk("side", 32'(side_light), 32'(exp_side()));
      chk("walk", 32'(walk), 32'(m_walk));
      chk("cset", 32'(counter_set), 32'(m_el == 0));
      chk("load", 32'(load), 32'(el));
      ok = (main_light == R) || (side_light == R) ||
           (main_light == side_light &&
            (main_light == Y || main_light == O));
      chk("invariant", 32'(ok), 32'd1);
   endtask

   task automatic step(bit r, bit sc, bit pr, bit fe);
      arstN = r; side_car = sc; ped_req = pr; flash_en = fe;
      @(posedge clk);
      model_step(r, sc, pr, fe);
      #1;
      compare_all();
   endtask

   task automatic run_to(int ph, int el, bit sc);
      for (int i = 0; i < 200; i++) begin
         if (m_ph == ph && m_el == el) break;
         step(1, sc, 0, 0);
      end
      chk("reach", 32'(m_ph == ph && m_el == el), 32'd1);
   endtask

   typedef struct {
      bit         r, sc, pr, fe;
      logic [2:0] m, s;
      bit         w, cs;
      logic [15:0] ld;
   } vec_t;

   vec_t vq[$];

   task automatic addp(bit sc, logic [2:0] m, logic [2:0] s,
                       logic [15:0] ld, int n, bit st);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.r = 1; v.sc = sc; v.pr = 0; v.fe = 0;
         v.m = m; v.s = s; v.w = 0;
         v.cs = st && (i == 0);
         v.ld = v.cs ? ld : 16'd0;
         vq.push_back(v);
      end
   endtask

   initial begin : main
      vec_t v;
      int bad, wc, sgn, sg_seen;
      bit sc, fe, pr;

      v.r = 0; v.sc = 1; v.pr = 0; v.fe = 0;
      v.m = R; v.s = R; v.w = 0; v.cs = 1; v.ld = 16'(TAR);
      vq.push_back(v);
      addp(1, R, R, 16'(TAR), 2, 0);
      addp(1, G, R, 16'(TMG), 6, 1);
      addp(1, Y, R, 16'(TMY), 4, 1);
      addp(1, R, R, 16'(TAR), 3, 1);
      addp(1, R, G, 16'(TSG), 5, 1);
      addp(1, R, Y, 16'(TSY), 4, 1);
      addp(1, R, R, 16'(TAR), 3, 1);
      addp(1, G, R, 16'(TMG), 1, 1);

      foreach (vq[i]) begin
         v = vq[i];
         step(v.r, v.sc, v.pr, v.fe);
         chk("tbl_main", 32'(main_light), 32'(v.m));
         chk("tbl_side", 32'(side_light), 32'(v.s));
         chk("tbl_walk", 32'(walk), 32'(v.w));
         chk("tbl_cset", 32'(counter_set), 32'(v.cs));
         chk("tbl_load", 32'(load), 32'(v.ld));
      end

      // MAIN_G with no demand holds without reloading
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("mg_entry", {29'd0, main_light}, 32'(G));
      chk("mg_strobe", 32'(counter_set), 32'd1);
      bad = 0;
      for (int i = 0; i < 25; i++) begin
         step(1, 0, 0, 0);
         if (main_light != G || counter_set) bad++;
      end
      chk("mg_hold", 32'(bad), 32'd0);

      // single ped pulse early in MAIN_G
      step(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      wc = 0;
      for (int i = 0; i < 45; i++) begin
         step(1, 0, 0, 0);
         if (walk) wc++;
      end
      chk("ped_walk_len", 32'(wc), 32'd5);
      chk("ped_cleared", {29'd0, main_light}, 32'(G));
      chk("ped_no_reload", 32'(counter_set), 32'd0);

      // ped held across the SIDE_G entry edge
      step(0, 0, 0, 0);
      sg_seen = 0; wc = 0;
      for (int i = 0; i < 75; i++) begin
         sc = (sg_seen == 0);
         pr = (m_ph == P_AR1 && sg_seen == 0) ||
              (m_ph == P_SG && m_el == 0 && sg_seen == 1);
         step(1, sc, pr, 0);
         if (walk) wc++;
         if (counter_set && side_light == G) sg_seen++;
      end
      chk("rearm_sg_count", 32'(sg_seen), 32'd2);
      chk("rearm_walk", 32'(wc), 32'd10);

      // flash entered mid SIDE_G
      step(0, 1, 0, 0);
      run_to(P_SG, 2, 1);
      step(1, 1, 0, 1);
      chk("fl_main", {29'd0, main_light}, 32'(Y));
      chk("fl_side", {29'd0, side_light}, 32'(Y));
      chk("fl_walk", 32'(walk), 32'd0);
      for (int k = 1; k < 12; k++) begin
         step(1, 1, 0, 1);
         chk("fl_blink", {29'd0, main_light},
             32'((((k / 4) % 2) == 0) ? Y : O));
      end
      step(1, 1, 0, 0);
      chk("fl_exit", {26'd0, main_light, side_light},
          32'({R, R}));
      chk("fl_exit_load", 32'(load), 32'(TAR));
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("fl_ar2", {29'd0, main_light}, 32'(R));
      step(1, 1, 0, 0);
      chk("fl_mg", {29'd0, main_light}, 32'(G));

      // reset mid MAIN_Y
      run_to(P_MY, 1, 1);
      step(0, 1, 0, 0);
      chk("rst_lamps", {26'd0, main_light, side_light},
          32'({R, R}));
      chk("rst_cset", 32'(counter_set), 32'd1);
      chk("rst_load", 32'(load), 32'd1);
      chk("rst_walk", 32'(walk), 32'd0);

      // random traffic against the reference model
      sc = 0; fe = 0; sgn = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) sc = !sc;
         if ($urandom_range(0, 59) == 0) fe = !fe;
         pr = ($urandom_range(0, 15) == 0);
         step($urandom_range(0, 199) != 0, sc, pr, fe);
         if (counter_set && side_light == G) sgn++;
      end
      chk("rand_side_served", 32'(sgn > 0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
